// File: rtl/aes_sbox_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox_arbiter_pkg
//  Purpose  : Shared constants for the S-box arbiter slice: AES byte counts,
//             FSM state encodings and the lane-count legality check.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package aes_sbox_arbiter_pkg;

   localparam int AES_STATE_BYTES = 16;
   localparam int AES_WORD_BYTES  = 4;

   localparam int       STATE_W = 3;
   localparam logic [STATE_W-1:0] IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] RUN_ST = 3'd1;
   localparam logic [STATE_W-1:0] RUN_KW = 3'd2;
   localparam logic [STATE_W-1:0] RSP_ST = 3'd3;
   localparam logic [STATE_W-1:0] RSP_KW = 3'd4;

   // Lane counts must divide the 4-byte key word evenly.
   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox_arbiter_if
//  Purpose  : Request/response channels between the two requesters (round
//             datapath = st_*, key expansion = kw_*) and the S-box arbiter.
//  Ports    : st_req_* / kw_req_*  request valid/ready/data
//             st_rsp_* / kw_rsp_*  response valid/ready/data
//             modport master = requester side, slave = arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface aes_sbox_arbiter_if;
   logic         st_req_valid;
   logic         st_req_ready;
   logic [127:0] st_req_data;
   logic         st_rsp_valid;
   logic         st_rsp_ready;
   logic [127:0] st_rsp_data;
   logic         kw_req_valid;
   logic         kw_req_ready;
   logic [31:0]  kw_req_data;
   logic         kw_rsp_valid;
   logic         kw_rsp_ready;
   logic [31:0]  kw_rsp_data;

   modport master (
      output st_req_valid, st_req_data, st_rsp_ready,
      output kw_req_valid, kw_req_data, kw_rsp_ready,
      input  st_req_ready, st_rsp_valid, st_rsp_data,
      input  kw_req_ready, kw_rsp_valid, kw_rsp_data
   );

   modport slave (
      input  st_req_valid, st_req_data, st_rsp_ready,
      input  kw_req_valid, kw_req_data, kw_rsp_ready,
      output st_req_ready, st_rsp_valid, st_rsp_data,
      output kw_req_ready, kw_rsp_valid, kw_rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/aes_sbox_arbiter_sbox.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox
//  Purpose  : Combinational AES forward S-box (FIPS-197 SubBytes table).
//  Ports    : in_byte  [7:0] in   byte to substitute
//             out_byte [7:0] out  S-box(in_byte)
//  Revision : 1.0 - initial release
// ============================================================================
module aes_sbox (
   input  wire logic [7:0] in_byte,
   output logic      [7:0] out_byte
);

   // Entry for input 0x00 sits in the top byte, entry 0xff in the bottom.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Inverting the input turns "entry n from the top" into a bit offset.
   assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_sbox_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox_arbiter
//  Purpose  : Shares LANES S-box instances between the round datapath
//             (128-bit SubBytes) and key expansion (32-bit SubWord). One job
//             at a time, round-robin on ties, LANES bytes per RUN cycle.
//  Ports    : clk  in   clock, rising edge
//             rst  in   synchronous active-high reset
//             bus  slave modport of aes_sbox_arbiter_if (req/rsp channels)
//             busy out  high whenever the FSM is not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_arbiter
   import aes_sbox_arbiter_pkg::*;
#(
   parameter int LANES    = 4,
   parameter bit KW_FIRST = 1'b1
) (
   input  wire logic          clk,
   input  wire logic          rst,
   aes_sbox_arbiter_if.slave  bus,
   output logic               busy
);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("aes_sbox_arbiter: LANES must be 1, 2 or 4");
   end

   localparam int CNT_W    = $clog2(AES_STATE_BYTES / LANES);
   localparam int LG_LANES = $clog2(LANES);
   localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(AES_STATE_BYTES / LANES - 1);
   localparam logic [CNT_W-1:0] KW_LAST = CNT_W'(AES_WORD_BYTES / LANES - 1);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_last_kw;     // 1 = key word was granted most recently
   logic [127:0]       r_operand;
   logic [127:0]       r_st_result;
   logic [31:0]        r_kw_result;

   logic               w_grant_kw;
   logic               w_grant_st;
   logic               w_acc_kw;
   logic               w_acc_st;
   logic [3:0]         w_idx      [LANES];
   logic [7:0]         w_sbox_out [LANES];

   // On a tie the requester that did not win last time takes the job.
   assign w_grant_kw = bus.kw_req_valid & (~bus.st_req_valid | ~r_last_kw);
   assign w_grant_st = bus.st_req_valid & (~bus.kw_req_valid |  r_last_kw);
   assign w_acc_kw   = (r_state == IDLE) & ~rst & w_grant_kw;
   assign w_acc_st   = (r_state == IDLE) & ~rst & w_grant_st;

   // Lane l handles byte cnt*LANES+l; LANES is a power of two, so this is a
   // concatenation of cnt with the lane number.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] w_sbox_in;
      assign w_idx[l]  = (4'(r_cnt) << LG_LANES) | 4'(l);
      assign w_sbox_in = r_operand[{w_idx[l], 3'b000} +: 8];
      aes_sbox u_sbox (
         .in_byte  (w_sbox_in),
         .out_byte (w_sbox_out[l])
      );
   end

   // State register and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_last_kw   <= ~KW_FIRST;
         r_operand   <= '0;
         r_st_result <= '0;
         r_kw_result <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc_kw || w_acc_st) begin
            r_operand <= w_acc_kw ? {96'b0, bus.kw_req_data} : bus.st_req_data;
            r_cnt     <= '0;
            r_last_kw <= w_acc_kw;
         end
         if (r_state == RUN_ST) begin
            for (int l = 0; l < LANES; l++)
               r_st_result[{w_idx[l], 3'b000} +: 8] <= w_sbox_out[l];
            r_cnt <= (r_cnt == ST_LAST) ? '0 : r_cnt + 1'b1;
         end
         if (r_state == RUN_KW) begin
            for (int l = 0; l < LANES; l++)
               r_kw_result[{w_idx[l][1:0], 3'b000} +: 8] <= w_sbox_out[l];
            r_cnt <= (r_cnt == KW_LAST) ? '0 : r_cnt + 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_acc_kw)      w_next = RUN_KW;
            else if (w_acc_st) w_next = RUN_ST;
         end
         RUN_ST:  if (r_cnt == ST_LAST)    w_next = RSP_ST;
         RUN_KW:  if (r_cnt == KW_LAST)    w_next = RSP_KW;
         RSP_ST:  if (bus.st_rsp_ready)    w_next = IDLE;
         RSP_KW:  if (bus.kw_rsp_ready)    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.st_req_ready = w_acc_st;
      bus.kw_req_ready = w_acc_kw;
      bus.st_rsp_valid = (r_state == RSP_ST);
      bus.kw_rsp_valid = (r_state == RSP_KW);
      bus.st_rsp_data  = r_st_result;
      bus.kw_rsp_data  = r_kw_result;
      busy             = (r_state != IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_sbox_arbiter
//  Purpose  : Directed self-checking bench for aes_sbox_arbiter (LANES=4 main
//             instance, LANES=1 and LANES=2 instances for latency sweep).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_arbiter;

   localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
   localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
   localparam logic [127:0] ALL_52   = {16{8'h52}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy4, busy1, busy2;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   aes_sbox_arbiter_if bus4 ();
   aes_sbox_arbiter_if bus1 ();
   aes_sbox_arbiter_if bus2 ();

   aes_sbox_arbiter #(.LANES(4), .KW_FIRST(1'b1)) u_dut4 (
      .clk (clk), .rst (rst), .bus (bus4), .busy (busy4));
   aes_sbox_arbiter #(.LANES(1), .KW_FIRST(1'b1)) u_dut1 (
      .clk (clk), .rst (rst), .bus (bus1), .busy (busy1));
   aes_sbox_arbiter #(.LANES(2), .KW_FIRST(1'b1)) u_dut2 (
      .clk (clk), .rst (rst), .bus (bus2), .busy (busy2));

   typedef struct {
      bit           is_kw;
      logic [127:0] din;
      logic [127:0] dout;
      int           lat;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic raise(input bit is_kw, input logic [127:0] din);
      if (is_kw) begin
         bus4.kw_req_valid = 1'b1;
         bus4.kw_req_data  = din[31:0];
      end else begin
         bus4.st_req_valid = 1'b1;
         bus4.st_req_data  = din;
      end
   endtask

   // Wait (bounded) until the requester is granted, then drop its valid just
   // after the accepting edge.
   task automatic wait_grant(input bit is_kw, input string name);
      int n = 0;
      #1;
      while (!(is_kw ? bus4.kw_req_ready : bus4.st_req_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, " grant"}, 128'(is_kw ? bus4.kw_req_ready : bus4.st_req_ready), 128'd1);
      @(posedge clk);
      #1;
      if (is_kw) bus4.kw_req_valid = 1'b0;
      else       bus4.st_req_valid = 1'b0;
   endtask

   // Called in cycle T+1; counts cycles until rsp_valid, checks latency and
   // data, optionally stalls rsp_ready, then completes the handshake.
   task automatic wait_rsp(input bit is_kw, input logic [127:0] dout, input int lat,
                           input int hold, input string name);
      int           k      = 0;
      bit           got    = 1'b0;
      bit           other  = 1'b0;
      bit           stable = 1'b1;
      logic [127:0] d0;
      while (!got && k < 30) begin
         @(negedge clk);
         k++;
         if (is_kw ? bus4.st_rsp_valid : bus4.kw_rsp_valid) other = 1'b1;
         got = is_kw ? bus4.kw_rsp_valid : bus4.st_rsp_valid;
      end
      chk({name, " rsp_valid"}, 128'(got), 128'd1);
      chk({name, " latency"}, 128'(k), 128'(lat));
      d0 = is_kw ? {96'b0, bus4.kw_rsp_data} : bus4.st_rsp_data;
      chk({name, " data"}, d0, dout);
      chk({name, " other rsp_valid"}, 128'(other), 128'd0);
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (is_kw) begin
               if (!bus4.kw_rsp_valid || {96'b0, bus4.kw_rsp_data} != d0 ||
                   bus4.st_req_ready || !busy4) stable = 1'b0;
            end else begin
               if (!bus4.st_rsp_valid || bus4.st_rsp_data != d0 ||
                   bus4.kw_req_ready || !busy4) stable = 1'b0;
            end
         end
         chk({name, " hold stable"}, 128'(stable), 128'd1);
      end
      if (is_kw) bus4.kw_rsp_ready = 1'b1;
      else       bus4.st_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus4.kw_rsp_ready = 1'b0;
      bus4.st_rsp_ready = 1'b0;
      @(negedge clk);
      chk({name, " idle after handshake"},
          128'({busy4, bus4.st_rsp_valid, bus4.kw_rsp_valid}), 128'd0);
   endtask

   task automatic run_job4(input bit is_kw, input logic [127:0] din,
                           input logic [127:0] dout, input int lat, input string name);
      raise(is_kw, din);
      wait_grant(is_kw, name);
      wait_rsp(is_kw, dout, lat, 0, name);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus4.st_req_valid = 1'b0;
      bus4.kw_req_valid = 1'b0;
      bus4.st_rsp_ready = 1'b0;
      bus4.kw_rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
   endtask

   // LANES=1 and LANES=2 instances get the same job together; rsp_ready is
   // tied high on them, so each response is visible for one cycle.
   task automatic sweep_job(input bit is_kw, input logic [127:0] din, input logic [127:0] dout,
                            input int lat1, input int lat2, input string name);
      int           l1 = -1;
      int           l2 = -1;
      logic [127:0] d1 = '0;
      logic [127:0] d2 = '0;
      if (is_kw) begin
         bus1.kw_req_valid = 1'b1; bus1.kw_req_data = din[31:0];
         bus2.kw_req_valid = 1'b1; bus2.kw_req_data = din[31:0];
      end else begin
         bus1.st_req_valid = 1'b1; bus1.st_req_data = din;
         bus2.st_req_valid = 1'b1; bus2.st_req_data = din;
      end
      #1;
      chk({name, " grant L1/L2"},
          128'(is_kw ? {bus1.kw_req_ready, bus2.kw_req_ready}
                     : {bus1.st_req_ready, bus2.st_req_ready}), 128'd3);
      @(posedge clk);
      #1;
      bus1.kw_req_valid = 1'b0; bus2.kw_req_valid = 1'b0;
      bus1.st_req_valid = 1'b0; bus2.st_req_valid = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (l1 < 0 && (is_kw ? bus1.kw_rsp_valid : bus1.st_rsp_valid)) begin
            l1 = k;
            d1 = is_kw ? {96'b0, bus1.kw_rsp_data} : bus1.st_rsp_data;
         end
         if (l2 < 0 && (is_kw ? bus2.kw_rsp_valid : bus2.st_rsp_valid)) begin
            l2 = k;
            d2 = is_kw ? {96'b0, bus2.kw_rsp_data} : bus2.st_rsp_data;
         end
      end
      chk({name, " L1 latency"}, 128'(l1), 128'(lat1));
      chk({name, " L1 data"}, d1, dout);
      chk({name, " L2 latency"}, 128'(l2), 128'(lat2));
      chk({name, " L2 data"}, d2, dout);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit no_rsp;

      bus4.st_req_valid = 1'b0; bus4.st_req_data = '0; bus4.st_rsp_ready = 1'b0;
      bus4.kw_req_valid = 1'b0; bus4.kw_req_data = '0; bus4.kw_rsp_ready = 1'b0;
      bus1.st_req_valid = 1'b0; bus1.st_req_data = '0; bus1.st_rsp_ready = 1'b1;
      bus1.kw_req_valid = 1'b0; bus1.kw_req_data = '0; bus1.kw_rsp_ready = 1'b1;
      bus2.st_req_valid = 1'b0; bus2.st_req_data = '0; bus2.st_rsp_ready = 1'b1;
      bus2.kw_req_valid = 1'b0; bus2.kw_req_data = '0; bus2.kw_rsp_ready = 1'b1;

      vecs[0] = '{1'b1, 128'hcf4f3c09, 128'h8a84eb01, 2};
      vecs[1] = '{1'b0, ALL_52,        128'h0,        5};
      vecs[2] = '{1'b1, 128'h00000000, 128'h63636363, 2};
      vecs[3] = '{1'b0, FIPS_IN,       FIPS_OUT,      5};
      vecs[4] = '{1'b1, 128'hff530100, 128'h16ed7c63, 2};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("reset busy", 128'(busy4), 128'd0);
      chk("reset rsp_valid", 128'({bus4.st_rsp_valid, bus4.kw_rsp_valid}), 128'd0);
      chk("reset req_ready", 128'({bus4.st_req_ready, bus4.kw_req_ready}), 128'd0);
      chk("reset st_rsp_data", bus4.st_rsp_data, 128'd0);
      chk("reset kw_rsp_data", 128'(bus4.kw_rsp_data), 128'd0);

      // Single-requester jobs from the vector table
      for (int i = 0; i < 5; i++)
         run_job4(vecs[i].is_kw, vecs[i].din, vecs[i].dout, vecs[i].lat, $sformatf("vec%0d", i));
      // The state result register was last written by the FIPS job
      chk("st result retained", bus4.st_rsp_data, FIPS_OUT);

      // Ties alternate kw, st, kw, st starting from reset
      apply_reset();
      for (int r = 0; r < 4; r++) begin
         bit exp_kw;
         exp_kw = (r % 2 == 0);
         raise(1'b1, 128'hcf4f3c09);
         raise(1'b0, FIPS_IN);
         #1;
         chk($sformatf("tie%0d ready", r),
             128'({bus4.kw_req_ready, bus4.st_req_ready}), exp_kw ? 128'd2 : 128'd1);
         wait_grant(exp_kw, $sformatf("tie%0d", r));
         wait_rsp(exp_kw, exp_kw ? 128'h8a84eb01 : FIPS_OUT, exp_kw ? 2 : 5, 0,
                  $sformatf("tie%0d", r));
      end

      // Stalled response: kw result held for 10 cycles while st waits
      apply_reset();
      raise(1'b1, 128'hcf4f3c09);
      wait_grant(1'b1, "stall kw");
      raise(1'b0, FIPS_IN);
      wait_rsp(1'b1, 128'h8a84eb01, 2, 10, "stall kw");
      wait_grant(1'b0, "stall st");
      wait_rsp(1'b0, FIPS_OUT, 5, 0, "stall st");

      // Reset two cycles into a state job drops it
      apply_reset();
      raise(1'b0, FIPS_IN);
      wait_grant(1'b0, "abort st");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort busy", 128'(busy4), 128'd0);
      chk("abort rsp_valid", 128'({bus4.st_rsp_valid, bus4.kw_rsp_valid}), 128'd0);
      chk("abort st_rsp_data", bus4.st_rsp_data, 128'd0);
      chk("abort kw_rsp_data", 128'(bus4.kw_rsp_data), 128'd0);
      no_rsp = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus4.st_rsp_valid || busy4) no_rsp = 1'b0;
      end
      chk("abort no response", 128'(no_rsp), 128'd1);
      run_job4(1'b1, 128'h00000000, 128'h63636363, 2, "after abort kw");

      // Lane-count sweep
      sweep_job(1'b1, 128'hff530100, 128'h16ed7c63, 5, 3, "sweep kw");
      sweep_job(1'b0, ALL_52, 128'h0, 17, 9, "sweep st");
      run_job4(1'b0, ALL_52, 128'h0, 5, "sweep st L4");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
